// File: rtl/data_mem_sized_if.sv
// Request/response bus between the MEM stage and the sized data memory.
interface data_mem_sized_if #(
   parameter int unsigned XLEN = 64
) ();
   logic            memread;
   logic            memwrite;
   logic [2:0]      funct3;
   logic [XLEN-1:0] addr;
   logic [XLEN-1:0] wdata;
   logic [XLEN-1:0] rdata;
   logic            ready;
   logic            fault;

   modport master (
      output memread, memwrite, funct3, addr, wdata,
      input  rdata, ready, fault
   );

   modport slave (
      input  memread, memwrite, funct3, addr, wdata,
      output rdata, ready, fault
   );
endinterface

// File: rtl/data_mem_sized.sv
// Byte-addressed little-endian data RAM with sized loads/stores, fixed
// access latency and a one-cycle ready/fault completion pulse.
module data_mem_sized #(
   parameter int unsigned XLEN    = 64,
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned LATENCY = 2
) (
   input logic             clk,
   input logic             rst,
   data_mem_sized_if.slave bus
);
   localparam int unsigned BYTES    = XLEN / 8;
   localparam int unsigned OFF      = $clog2(BYTES);
   localparam int unsigned AW       = $clog2(DEPTH);
   localparam int unsigned CW       = (LATENCY > 2) ? $clog2(LATENCY) : 1;
   localparam int unsigned CNT_INIT = (LATENCY >= 2) ? LATENCY - 2 : 0;
   localparam int unsigned SW       = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

   state_e              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                is_wr_q, is_wr_d;
   logic                err_q, err_d;
   logic [2:0]          f3_q, f3_d;
   logic [OFF+AW-1:0]   addr_q, addr_d;
   logic [XLEN-1:0]     wdata_q, wdata_d;
   logic [XLEN-1:0]     rdata_q, rdata_d;
   logic                ready_q, ready_d;
   logic                fault_q, fault_d;

   logic [XLEN-1:0]     mem [DEPTH];

   logic [3:0]          req_size_c;
   logic                req_fault_c;
   logic [AW-1:0]       idx_c;
   logic [OFF-1:0]      off_c;
   int                  nbytes_c;
   int                  nbits_c;
   logic [SW-1:0]       sign_idx_c;
   logic [XLEN-1:0]     word_c, shifted_c, load_c, wshift_c;
   logic [BYTES-1:0]    be_c;
   logic                wr_en_c;

   // Upper address bits are ignored so addresses wrap at DEPTH*BYTES.
   logic addr_hi_unused;
   assign addr_hi_unused = ^bus.addr[XLEN-1:OFF+AW];

   // Classify the incoming request: illegal funct3, misalignment, read+write clash.
   always_comb begin
      req_size_c  = 4'd1 << bus.funct3[1:0];
      req_fault_c = (bus.funct3 == 3'b111)
                 || ((XLEN == 32) && ((bus.funct3 == 3'b011) || (bus.funct3 == 3'b110)))
                 || ((bus.addr[2:0] & 3'(req_size_c - 4'd1)) != 3'd0)
                 || (bus.memread && bus.memwrite);
   end

   // Completion datapath on the captured request: load extraction and store lanes.
   always_comb begin
      idx_c      = addr_q[OFF+AW-1:OFF];
      off_c      = addr_q[OFF-1:0];
      nbytes_c   = 32'd1 << f3_q[1:0];
      nbits_c    = nbytes_c * 8;
      sign_idx_c = SW'(nbits_c - 1);
      word_c     = mem[idx_c];
      shifted_c  = word_c >> {off_c, 3'b000};
      load_c     = '0;
      for (int i = 0; i < XLEN; i++) begin
         load_c[i] = (i < nbits_c) ? shifted_c[i] : (!f3_q[2] && shifted_c[sign_idx_c]);
      end
      be_c = '0;
      for (int b = 0; b < BYTES; b++) begin
         be_c[b] = (b >= int'(off_c)) && (b < int'(off_c) + nbytes_c);
      end
      wshift_c = wdata_q << {off_c, 3'b000};
      wr_en_c  = (state_q == RESP) && is_wr_q && !err_q && !rst;
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      is_wr_d = is_wr_q;
      err_d   = err_q;
      f3_d    = f3_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      ready_d = 1'b0;
      fault_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.memread || bus.memwrite) begin
               is_wr_d = bus.memwrite;
               err_d   = req_fault_c;
               f3_d    = bus.funct3;
               addr_d  = bus.addr[OFF+AW-1:0];
               wdata_d = bus.wdata;
               if (LATENCY == 1) begin
                  state_d = RESP;
               end else begin
                  state_d = BUSY;
                  cnt_d   = CW'(CNT_INIT);
               end
            end
         end
         BUSY: begin
            if (cnt_q == '0) state_d = RESP;
            else             cnt_d   = cnt_q - CW'(1);
         end
         RESP: begin
            ready_d = 1'b1;
            fault_d = err_q;
            if (!is_wr_q && !err_q) rdata_d = load_c;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control/state registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         is_wr_q <= 1'b0;
         err_q   <= 1'b0;
         f3_q    <= 3'd0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         ready_q <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         is_wr_q <= is_wr_d;
         err_q   <= err_d;
         f3_q    <= f3_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
         fault_q <= fault_d;
      end
   end

   // Storage array: byte-lane write at store completion; contents not reset.
   always_ff @(posedge clk) begin
      if (wr_en_c) begin
         for (int b = 0; b < BYTES; b++) begin
            if (be_c[b]) mem[idx_c][8*b +: 8] <= wshift_c[8*b +: 8];
         end
      end
   end

   assign bus.rdata = rdata_q;
   assign bus.ready = ready_q;
   assign bus.fault = fault_q;
endmodule

// File: doc/data_mem_sized.md
Name: data_mem_sized

Overview:
Parametrised successor to the fixed 64-bit data memory. Byte-addressed, little-endian data RAM for the RISC-V MEM stage. Supports sized loads/stores (byte/half/word/double) selected by funct3, with sign or zero extension and a misalignment fault. A fixed configurable access latency is presented through a single-cycle `ready` completion handshake, so the pipeline can stall on memory.

Parameters:
- XLEN, 64, data width in bits; 32 or 64 only.
- DEPTH, 256, number of XLEN-bit words; power of two.
- LATENCY, 2, cycles from request acceptance to completion; must be ≥1.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- memread  input  1  load request.
- memwrite  input  1  store request.
- funct3  input  3  access size/extension (RISC-V load/store funct3 encoding).
- addr  input  XLEN  byte address.
- wdata  input  XLEN  store data; low bytes used per size.
- rdata  output  XLEN  extended load result; holds last completed load.
- ready  output  1  one-cycle completion pulse.
- fault  output  1  one-cycle pulse with ready when the access was rejected.

Behaviour:
- Storage and address decode:
  - Storage is DEPTH × XLEN bits. BYTES=XLEN/8, OFF=log2(BYTES), AW=log2(DEPTH).
  - Word index = addr[OFF+AW-1:OFF]. Upper address bits are ignored, so addresses wrap at DEPTH*BYTES.
  - Memory contents are not reset.
- funct3 encoding:
  - 000 LB/SB, 001 LH/SH, 010 LW/SW, 011 LD/SD, 100 LBU, 101 LHU, 110 LWU.
  - 111 is illegal.
  - When XLEN=32, 011 and 110 are also illegal.
  - Stores honour funct3[1:0] only.
- Alignment: an access is aligned when addr modulo the size (1/2/4/8 bytes) equals 0.
- Loads:
  - The selected bytes are extracted little-endian from the word at offset addr[OFF-1:0].
  - Signed sizes sign-extend to XLEN; U variants zero-extend.
- Stores: only the addressed byte lanes are written; all other bytes of the word keep their values.
- FSM states: IDLE, BUSY, RESP.
  - IDLE: if memread or memwrite is high, capture op, funct3, addr and wdata.
    - Go to RESP when LATENCY=1.
    - Otherwise go to BUSY with cnt=LATENCY-2.
  - BUSY: when cnt==0 go to RESP, else cnt-1.
  - RESP: ready=1 for exactly this cycle, then go to IDLE.
- Timing and handshake:
  - A request accepted at edge k completes at edge k+LATENCY, where completion means the memory write and rdata update. ready is high in the following cycle.
  - Inputs are ignored outside IDLE.
  - The earliest next acceptance is at edge k+LATENCY+1.
  - A request still asserted in the IDLE cycle after RESP is accepted as a new access; the requester drops memread/memwrite on seeing ready.
- Fault conditions:
  - Misaligned address, illegal funct3, or memread and memwrite both high at acceptance.
  - Latency is unchanged for a faulting access; fault=ready=1 in RESP.
  - No memory write occurs and rdata is unchanged.
- Output hold rules:
  - rdata updates only on a successful load completion and is otherwise held.
  - A store completion leaves rdata unchanged.
- Reset (asynchronous, any time):
  - Outputs: rdata=0, ready=0, fault=0.
  - Internal: state=IDLE, cnt=0.
  - An in-flight store is discarded (memory unchanged) and an in-flight load produces no ready.
  - The first acceptance is at the first rising edge with rst low.

Test Plan (XLEN=64, DEPTH=256, LATENCY=2 unless stated):
1. SD 0xDEADBEEFCAFEBABE @0x0, then LD @0x0:
   - ready is high exactly 2 cycles after the acceptance edge.
   - rdata=0xDEADBEEFCAFEBABE and fault=0.
2. SB wdata=0x80 @0x3:
   - LB @0x3 returns 0xFFFFFFFFFFFFFF80.
   - LBU @0x3 returns 0x0000000000000080.
   - LD @0x0 returns 0xDEADBEEF80FEBABE.
3. Word loads @0x4: LW returns 0xFFFFFFFFDEADBEEF; LWU returns 0x00000000DEADBEEF.
4. Faulting requests, each giving ready=fault=1 with no write:
   - SD 0x0123456789ABCDEF @0x8; SH 0xFFFF @0x9 (misaligned); funct3=111 @0x8; memread=memwrite=1 @0x8.
   - LD @0x8 still returns 0x0123456789ABCDEF.
   - rdata is unchanged across the faulting accesses.
5. Reset in flight: SD 0x1111 @0x10 (prior value 0), assert rst during BUSY.
   - ready never pulses and rdata=0.
   - After release, LD @0x10 returns 0.
6. LATENCY=1 and LATENCY=5 builds, plus wrap-around:
   - ready arrives 1 and 5 cycles after acceptance respectively.
   - A request held high continuously is re-accepted every LATENCY+1 cycles.
   - SD @0x800 aliases @0x0, and LD @0x0 returns the stored value.
